cdr_phase_picker: RTL and testbench

Consumes 4-sample nibbles from the 4x oversampling front end and recovers the serial bit stream. Detects data edges in each nibble, tracks the eye centre with a filtered phase pointer and picks one sample per unit interval. When the pointer wraps it emits 0 or 2 bits to absorb transmitter/receiver clock drift. Sits directly downstream of the 4x sampler in the CDR data-recovery path, feeding the deserializer/aligner.

---
 rtl/cdr_phase_picker.sv | 139 +++++++++++++
 tb/tb_cdr_phase_picker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cdr_phase_picker.sv
// 4x-oversampled CDR phase picker: edge detect, filtered phase pointer, 0/1/2-bit emission.
// Optional vote filter enabled by defining CDR_PICKER_FILTER_EN; without it every vote steps.
module cdr_phase_picker #(
  parameter int LOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       out_valid,
  output logic [1:0] out_count,
  output logic [1:0] out_data,
  output logic [1:0] out_phase
);

  if (LOCK_CNT < 1) begin : g_lock_cnt_check
    $error("LOCK_CNT must be >= 1");
  end

  logic [1:0] p_q, p_d;
  logic       prev_s3_q, prev_s3_d;
  logic       out_valid_q, out_valid_d;
  logic [1:0] out_count_q, out_count_d;
  logic [1:0] out_data_q, out_data_d;

  logic [3:0] e;
  logic       has_edge;
  logic [1:0] pos, target, diff;
  logic       vote_up, vote_dn;
  logic       step_up, step_dn;

`ifdef CDR_PICKER_FILTER_EN
  localparam int CW = $clog2(LOCK_CNT + 1);
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  // dir_q = 1 means the last vote was "up"
  logic          dir_q, dir_d;
`endif

  always_comb begin
    e        = {in_data[3] ^ in_data[2], in_data[2] ^ in_data[1],
                in_data[1] ^ in_data[0], in_data[0] ^ prev_s3_q};
    has_edge = |e;
    pos      = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (e[i]) pos = 2'(i);
    end
    // Eye centre sits two samples after the data transition.
    target  = pos + 2'd2;
    diff    = target - p_q;
    vote_up = has_edge && (diff == 2'd1);
    vote_dn = has_edge && (diff == 2'd3);
    step_up = 1'b0;
    step_dn = 1'b0;
`ifdef CDR_PICKER_FILTER_EN
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    cnt_inc = '0;
    if (in_valid) begin
      if (vote_up || vote_dn) begin
        if (vote_up == dir_q) begin
          cnt_inc = cnt_q + 1'b1;
        end else begin
          cnt_inc = CW'(1);
          dir_d   = vote_up;
        end
        if (cnt_inc == CW'(LOCK_CNT)) begin
          cnt_d   = '0;
          step_up = vote_up;
          step_dn = vote_dn;
        end else begin
          cnt_d = cnt_inc;
        end
      end else if (has_edge) begin
        cnt_d = '0;
      end
    end
`else
    step_up = in_valid && vote_up;
    step_dn = in_valid && vote_dn;
`endif
  end

  always_comb begin
    p_d         = p_q;
    prev_s3_d   = prev_s3_q;
    out_count_d = 2'd0;
    out_data_d  = out_data_q;
    if (step_up)      p_d = p_q + 2'd1;
    else if (step_dn) p_d = p_q - 2'd1;
    if (in_valid) begin
      prev_s3_d = in_data[3];
      if (step_up && p_q == 2'd3) begin
        out_count_d = 2'd0;
      end else if (step_dn && p_q == 2'd0) begin
        // Pointer slipped back a UI: emit the previous nibble's last sample too.
        out_count_d = 2'd2;
        out_data_d  = {in_data[3], prev_s3_q};
      end else begin
        out_count_d = 2'd1;
        out_data_d  = {1'b0, in_data[p_d]};
      end
    end
    out_valid_d = (out_count_d != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q         <= 2'd2;
      prev_s3_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= 2'd0;
      out_data_q  <= 2'd0;
    end else begin
      p_q         <= p_d;
      prev_s3_q   <= prev_s3_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef CDR_PICKER_FILTER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_data  = out_data_q;
  assign out_phase = p_q;

endmodule

// File: tb/tb_cdr_phase_picker.sv
// Bench for cdr_phase_picker: table vectors, corner sequences, randomized traffic vs reference model.
module tb_cdr_phase_picker;
  localparam int LOCK = 4;
`ifdef CDR_PICKER_FILTER_EN
  localparam int NV = LOCK;
`else
  localparam int NV = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_valid;
  logic [1:0] out_count, out_data, out_phase;

  cdr_phase_picker #(.LOCK_CNT(LOCK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_count(out_count), .out_data(out_data),
    .out_phase(out_phase)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state, plain integers
  int m_p, m_cnt, m_dir, m_prev;
  int e_valid, e_count, e_data;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    m_p = 2; m_cnt = 0; m_dir = 0; m_prev = 0;
    e_valid = 0; e_count = 0; e_data = 0;
  endtask

  task automatic mdl(input logic v, input logic [3:0] n);
    int pos, last, d, vd, step, oldp;
    if (!v) begin
      e_valid = 0; e_count = 0;
      return;
    end
    pos = -1; last = m_prev;
    for (int i = 0; i < 4; i++) begin
      if (pos < 0 && int'(n[i]) != last) pos = i;
      last = int'(n[i]);
    end
    oldp = m_p; step = 0;
    if (pos >= 0) begin
      d = ((pos + 2) - m_p + 8) % 4;
      if (d == 1 || d == 3) begin
        vd = (d == 1) ? 1 : -1;
`ifdef CDR_PICKER_FILTER_EN
        if (vd == m_dir) m_cnt++;
        else begin m_dir = vd; m_cnt = 1; end
        if (m_cnt == LOCK) begin step = vd; m_cnt = 0; end
`else
        step = vd;
`endif
      end else begin
        m_cnt = 0;
      end
    end
    m_p = (m_p + step + 4) % 4;
    if (step == 1 && oldp == 3) begin
      e_count = 0;
    end else if (step == -1 && oldp == 0) begin
      e_count = 2; e_data = int'(n[3]) * 2 + m_prev;
    end else begin
      e_count = 1; e_data = int'(n[m_p]);
    end
    e_valid = (e_count != 0) ? 1 : 0;
    m_prev = int'(n[3]);
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".valid"}, int'(out_valid), e_valid);
    chk({tag, ".count"}, int'(out_count), e_count);
    chk({tag, ".phase"}, int'(out_phase), m_p);
    if (e_count == 2)      chk({tag, ".data"}, int'(out_data), e_data);
    else if (e_count == 1) chk({tag, ".data0"}, int'(out_data[0]), e_data);
  endtask

  // drive one cycle, step model, compare at the following negedge
  task automatic cyc(input logic v, input logic [3:0] n, input string tag);
    in_valid = v; in_data = n;
    @(posedge clk);
    @(negedge clk);
    mdl(v, n);
    cmp_model(tag);
  endtask

  function automatic logic [3:0] mk(input int pos, input int prev);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (i < pos) ? prev[0] : ~prev[0];
    return r;
  endfunction

  typedef struct {
    logic       v;
    logic [3:0] nib;
    int         valid, count, data0, phase;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 4'b1111, 1, 1, 1, 2};
    tbl[1] = '{1'b1, 4'b0000, 1, 1, 0, 2};
    tbl[2] = '{1'b1, 4'b1111, 1, 1, 1, 2};
    tbl[3] = '{1'b0, 4'b0101, 0, 0, 1, 2};
    tbl[4] = '{1'b1, 4'b0000, 1, 1, 0, 2};
    tbl[5] = '{1'b1, 4'b1111, 1, 1, 1, 2};

    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0;
    mdl_reset();
    #1;
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.count", int'(out_count), 0);
    chk("rst.data",  int'(out_data), 0);
    chk("rst.phase", int'(out_phase), 2);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'h0, "idle");
      chk("idle.data", int'(out_data), 0);
    end

    // steady lock vectors
    for (int i = 0; i < 6; i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].nib;
      @(posedge clk);
      @(negedge clk);
      mdl(tbl[i].v, tbl[i].nib);
      chk("tbl.valid", int'(out_valid), tbl[i].valid);
      chk("tbl.count", int'(out_count), tbl[i].count);
      chk("tbl.data0", int'(out_data[0]), tbl[i].data0);
      chk("tbl.phase", int'(out_phase), tbl[i].phase);
    end
    cyc(1'b1, 4'b0000, "tbl.tail");

    // up votes from p=2; with the filter, a no-edge nibble must not lose the count
`ifdef CDR_PICKER_FILTER_EN
    for (int i = 0; i < LOCK - 1; i++) cyc(1'b1, mk(1, m_prev), "up");
    chk("up.hold3", int'(out_phase), 2);
    cyc(1'b1, {4{m_prev[0]}}, "noedge");
    chk("noedge.phase", int'(out_phase), 2);
    cyc(1'b1, mk(1, m_prev), "up.last");
`else
    cyc(1'b1, mk(1, m_prev), "up.single");
`endif
    chk("up.stepped", int'(out_phase), 3);

    // wrap up 3 -> 0: zero bits emitted
    for (int i = 0; i < NV; i++) cyc(1'b1, mk(2, m_prev), "wrap0");
    chk("wrap0.valid", int'(out_valid), 0);
    chk("wrap0.count", int'(out_count), 0);
    chk("wrap0.phase", int'(out_phase), 0);

    // wrap down 0 -> 3: final vote sees prev_s3=1 with nibble 0001
    if (NV % 2 == 0) cyc(1'b1, 4'b0000, "align");
    else             cyc(1'b1, 4'b1111, "align");
    for (int i = 0; i < NV; i++) cyc(1'b1, mk(1, m_prev), "wrap2");
    chk("wrap2.nib", int'(in_data), 4'b0001);
    chk("wrap2.count", int'(out_count), 2);
    chk("wrap2.data", int'(out_data), 2'b01);
    chk("wrap2.phase", int'(out_phase), 3);

    // ambiguous edge (target = p+2) clears the count and never steps
`ifdef CDR_PICKER_FILTER_EN
    for (int i = 0; i < LOCK - 1; i++) cyc(1'b1, mk(2, m_prev), "pre.amb");
`endif
    cyc(1'b1, mk(3, m_prev), "amb");
    chk("amb.phase", int'(out_phase), 3);
`ifdef CDR_PICKER_FILTER_EN
    for (int i = 0; i < LOCK - 1; i++) cyc(1'b1, mk(2, m_prev), "post.amb");
    chk("amb.cleared", int'(out_phase), 3);
`endif

    // async reset mid-stream, between clock edges
    rst = 1'b1;
    #1;
    mdl_reset();
    chk("arst.valid", int'(out_valid), 0);
    chk("arst.count", int'(out_count), 0);
    chk("arst.data",  int'(out_data), 0);
    chk("arst.phase", int'(out_phase), 2);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 4'b0111, "post.rst");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic v;
      logic [3:0] n;
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       n = 4'($urandom);
        1:       n = {4{m_prev[0]}};
        default: n = mk($urandom_range(0, 3), m_prev);
      endcase
      cyc(v, n, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
